// File: rtl/ftq_queue_if.sv
// Handshake and data bundle between the fetch target queue and its producer/consumers.
// The master modport is the environment side (predictor, fetch unit, backend); the slave modport is the queue.
interface ftq_queue_if #(
    parameter int VLEN   = 32,
    parameter int IDX_W  = 3,
    parameter int SLOT_W = 2
);
    logic              enq_valid_i;
    logic              enq_ready_o;
    logic [VLEN-1:0]   enq_pc_i;
    logic              enq_taken_i;
    logic [SLOT_W-1:0] enq_slot_i;
    logic [VLEN-1:0]   enq_target_i;

    logic              fetch_valid_o;
    logic              fetch_ready_i;
    logic [IDX_W:0]    fetch_idx_o;
    logic [VLEN-1:0]   fetch_pc_o;
    logic              fetch_taken_o;
    logic [SLOT_W-1:0] fetch_slot_o;
    logic [VLEN-1:0]   fetch_target_o;

    logic              commit_valid_i;
    logic              flush_i;
    logic [IDX_W:0]    flush_ptr_i;

    logic [IDX_W-1:0]  rd_idx_i;
    logic [VLEN-1:0]   rd_pc_o;
    logic [IDX_W:0]    count_o;
    logic              empty_o;

    modport master (
        output enq_valid_i, enq_pc_i, enq_taken_i, enq_slot_i, enq_target_i,
        output fetch_ready_i, commit_valid_i, flush_i, flush_ptr_i, rd_idx_i,
        input  enq_ready_o, fetch_valid_o, fetch_idx_o, fetch_pc_o,
        input  fetch_taken_o, fetch_slot_o, fetch_target_o,
        input  rd_pc_o, count_o, empty_o
    );

    modport slave (
        input  enq_valid_i, enq_pc_i, enq_taken_i, enq_slot_i, enq_target_i,
        input  fetch_ready_i, commit_valid_i, flush_i, flush_ptr_i, rd_idx_i,
        output enq_ready_o, fetch_valid_o, fetch_idx_o, fetch_pc_o,
        output fetch_taken_o, fetch_slot_o, fetch_target_o,
        output rd_pc_o, count_o, empty_o
    );
endinterface

// File: rtl/ftq_queue.sv
// Fetch target queue: circular buffer with enqueue, fetch and commit pointers
// and partial flush on branch redirect.
module ftq_queue #(
    parameter int FTQ_DEPTH       = 8,
    parameter int VLEN            = 32,
    parameter int INSTR_PER_FETCH = 4,
    localparam int IDX_W          = $clog2(FTQ_DEPTH),
    localparam int SLOT_W         = $clog2(INSTR_PER_FETCH)
) (
    input logic        clk_i,
    input logic        rst_i,
    ftq_queue_if.slave q
);
    typedef logic [IDX_W:0] ptr_t;

    ptr_t enq_ptr;
    ptr_t fetch_ptr;
    ptr_t commit_ptr;

    logic [VLEN-1:0]   pc_mem     [FTQ_DEPTH];
    logic              taken_mem  [FTQ_DEPTH];
    logic [SLOT_W-1:0] slot_mem   [FTQ_DEPTH];
    logic [VLEN-1:0]   target_mem [FTQ_DEPTH];

    logic full;
    logic fetch_avail;
    logic enq_fire;
    logic fetch_fire;
    logic commit_fire;

    // Handshakes are qualified with reset and flush so that neither one
    // writes storage nor moves a pointer in a cycle that discards them.
    always_comb begin
        full        = (enq_ptr[IDX_W-1:0] == commit_ptr[IDX_W-1:0]) &&
                      (enq_ptr[IDX_W] != commit_ptr[IDX_W]);
        fetch_avail = (fetch_ptr != enq_ptr);
        enq_fire    = q.enq_valid_i && !full && !q.flush_i && !rst_i;
        fetch_fire  = fetch_avail && q.fetch_ready_i && !q.flush_i && !rst_i;
        commit_fire = q.commit_valid_i && (commit_ptr != fetch_ptr) && !rst_i;
    end

    assign q.enq_ready_o    = !full;
    assign q.fetch_valid_o  = fetch_avail;
    assign q.fetch_idx_o    = fetch_ptr;
    assign q.fetch_pc_o     = pc_mem[fetch_ptr[IDX_W-1:0]];
    assign q.fetch_taken_o  = taken_mem[fetch_ptr[IDX_W-1:0]];
    assign q.fetch_slot_o   = slot_mem[fetch_ptr[IDX_W-1:0]];
    assign q.fetch_target_o = target_mem[fetch_ptr[IDX_W-1:0]];
    assign q.rd_pc_o        = pc_mem[q.rd_idx_i];
    assign q.count_o        = enq_ptr - commit_ptr;
    assign q.empty_o        = (enq_ptr == commit_ptr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enq_ptr    <= '0;
            fetch_ptr  <= '0;
            commit_ptr <= '0;
        end else begin
            if (q.flush_i) begin
                enq_ptr   <= q.flush_ptr_i + ptr_t'(1);
                fetch_ptr <= q.flush_ptr_i + ptr_t'(1);
            end else begin
                if (enq_fire)   enq_ptr   <= enq_ptr + ptr_t'(1);
                if (fetch_fire) fetch_ptr <= fetch_ptr + ptr_t'(1);
            end
            if (commit_fire) commit_ptr <= commit_ptr + ptr_t'(1);
        end
    end

    // Storage is never reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            pc_mem[enq_ptr[IDX_W-1:0]]     <= q.enq_pc_i;
            taken_mem[enq_ptr[IDX_W-1:0]]  <= q.enq_taken_i;
            slot_mem[enq_ptr[IDX_W-1:0]]   <= q.enq_slot_i;
            target_mem[enq_ptr[IDX_W-1:0]] <= q.enq_target_i;
        end
    end
endmodule

// File: tb/tb_ftq_queue.sv
// Directed, table-driven bench for ftq_queue: one record per clock cycle holding
// the inputs for that cycle and the outputs expected just before its rising edge.
module tb_ftq_queue;
    localparam int VLEN   = 32;
    localparam int IDX_W  = 3;
    localparam int SLOT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ftq_queue_if #(.VLEN(VLEN), .IDX_W(IDX_W), .SLOT_W(SLOT_W)) bus ();

    ftq_queue #(.FTQ_DEPTH(8), .VLEN(VLEN), .INSTR_PER_FETCH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        ev;
        logic [31:0] pc;
        logic        fr;
        logic        cv;
        logic        fl;
        logic [3:0]  fp;
        logic [2:0]  ri;
        logic        cs;
        logic        cp;
        logic        cr;
        logic        e_ready;
        logic        e_fv;
        logic [3:0]  e_cnt;
        logic [3:0]  e_fidx;
        logic [31:0] e_fpc;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Side fields of every enqueued block are derived from its PC.
    function automatic logic       f_taken(input logic [31:0] pc); return pc[4];          endfunction
    function automatic logic [1:0] f_slot(input logic [31:0] pc);  return pc[5:4];        endfunction
    function automatic logic [31:0] f_tgt(input logic [31:0] pc);  return pc + 32'h100;   endfunction

    function automatic vec_t nop();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t exp_st(input vec_t vin, input logic rdy, input logic fv,
                                    input int cnt, input int fidx);
        vec_t v = vin;
        v.cs = 1'b1; v.e_ready = rdy; v.e_fv = fv;
        v.e_cnt = 4'(cnt); v.e_fidx = 4'(fidx);
        return v;
    endfunction

    function automatic vec_t exp_pc(input vec_t vin, input logic [31:0] pc);
        vec_t v = vin;
        v.cp = 1'b1; v.e_fpc = pc;
        return v;
    endfunction

    function automatic vec_t exp_rd(input vec_t vin, input int idx, input logic [31:0] pc);
        vec_t v = vin;
        v.cr = 1'b1; v.ri = 3'(idx); v.e_rpc = pc;
        return v;
    endfunction

    function automatic vec_t enq(input vec_t vin, input logic [31:0] pc);
        vec_t v = vin;
        v.ev = 1'b1; v.pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, act, exp);
    endtask

    task automatic build();
        vec_t v;
        // Initial reset, then single enqueue latency.
        v = nop(); v.rst = 1'b1; vecs.push_back(v);
        v = exp_st(enq(nop(), 32'h2000), 1, 0, 0, 0); vecs.push_back(v);
        v = exp_pc(exp_st(nop(), 1, 1, 1, 0), 32'h2000); vecs.push_back(v);
        v = exp_st(nop(), 1, 1, 1, 0); v.rst = 1'b1; vecs.push_back(v);

        // Fill eight, offer a ninth, fetch eight, commit eight, enqueue three.
        for (int i = 0; i < 8; i++) begin
            v = exp_st(enq(nop(), 32'h1000 + 32'(16 * i)), 1, i > 0, i, 0);
            if (i > 0) v = exp_pc(v, 32'h1000);
            vecs.push_back(v);
        end
        v = exp_pc(exp_st(enq(nop(), 32'h1080), 0, 1, 8, 0), 32'h1000);
        vecs.push_back(v);
        for (int j = 0; j < 8; j++) begin
            v = exp_pc(exp_st(nop(), 0, 1, 8, j), 32'h1000 + 32'(16 * j));
            v.fr = 1'b1;
            if (j == 0) v = exp_rd(v, 7, 32'h1070);
            vecs.push_back(v);
        end
        for (int j = 0; j < 8; j++) begin
            v = exp_st(nop(), j > 0, 0, 8 - j, 8);
            v.cv = 1'b1;
            vecs.push_back(v);
        end
        for (int i = 0; i < 3; i++) begin
            v = exp_st(enq(nop(), 32'h3000 + 32'(16 * i)), 1, i > 0, i, 8);
            if (i > 0) v = exp_pc(v, 32'h3000);
            vecs.push_back(v);
        end
        // Wrap-bit fetch index, random read, and an illegal commit (fetch == commit).
        v = exp_rd(exp_pc(exp_st(nop(), 1, 1, 3, 8), 32'h3000), 1, 32'h3010);
        v.cv = 1'b1; vecs.push_back(v);
        v = exp_st(nop(), 1, 1, 3, 8); v.fr = 1'b1; vecs.push_back(v);
        v = exp_pc(exp_st(enq(nop(), 32'h3030), 1, 1, 3, 9), 32'h3010); vecs.push_back(v);
        // Simultaneous enqueue, fetch and commit at half occupancy.
        v = exp_pc(exp_st(enq(nop(), 32'h3040), 1, 1, 4, 9), 32'h3010);
        v.fr = 1'b1; v.cv = 1'b1; vecs.push_back(v);
        v = exp_rd(exp_pc(exp_st(nop(), 1, 1, 4, 10), 32'h3020), 4, 32'h3040);
        vecs.push_back(v);

        // Partial flush: enqueue 6, fetch 5, commit 1, flush to pointer 2 with a concurrent enqueue.
        v = nop(); v.rst = 1'b1; vecs.push_back(v);
        for (int i = 0; i < 6; i++) begin
            v = exp_st(enq(nop(), 32'h4000 + 32'(16 * i)), 1, i > 0, i, 0);
            vecs.push_back(v);
        end
        for (int j = 0; j < 5; j++) begin
            v = exp_pc(exp_st(nop(), 1, 1, 6, j), 32'h4000 + 32'(16 * j));
            v.fr = 1'b1; vecs.push_back(v);
        end
        v = exp_st(nop(), 1, 1, 6, 5); v.cv = 1'b1; vecs.push_back(v);
        v = exp_st(enq(nop(), 32'h4F00), 1, 1, 5, 5);
        v.fr = 1'b1; v.fl = 1'b1; v.fp = 4'd2; vecs.push_back(v);
        v = exp_rd(exp_st(nop(), 1, 0, 2, 3), 3, 32'h4030); vecs.push_back(v);

        // Reset with five entries live and an enqueue offered.
        for (int i = 0; i < 3; i++) begin
            v = exp_st(enq(nop(), 32'h5000 + 32'(16 * i)), 1, i > 0, 2 + i, 3);
            if (i > 0) v = exp_pc(v, 32'h5000);
            vecs.push_back(v);
        end
        v = exp_st(enq(nop(), 32'h5F00), 1, 1, 5, 3); v.rst = 1'b1; vecs.push_back(v);
        v = exp_rd(exp_st(nop(), 1, 0, 0, 0), 6, 32'h1060); vecs.push_back(v);
        v = exp_rd(nop(), 5, 32'h5020); vecs.push_back(v);
    endtask

    initial begin
        bus.enq_valid_i    = 1'b0;
        bus.enq_pc_i       = '0;
        bus.enq_taken_i    = 1'b0;
        bus.enq_slot_i     = '0;
        bus.enq_target_i   = '0;
        bus.fetch_ready_i  = 1'b0;
        bus.commit_valid_i = 1'b0;
        bus.flush_i        = 1'b0;
        bus.flush_ptr_i    = '0;
        bus.rd_idx_i       = '0;
        build();

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst                = vecs[r].rst;
            bus.enq_valid_i    = vecs[r].ev;
            bus.enq_pc_i       = vecs[r].pc;
            bus.enq_taken_i    = f_taken(vecs[r].pc);
            bus.enq_slot_i     = f_slot(vecs[r].pc);
            bus.enq_target_i   = f_tgt(vecs[r].pc);
            bus.fetch_ready_i  = vecs[r].fr;
            bus.commit_valid_i = vecs[r].cv;
            bus.flush_i        = vecs[r].fl;
            bus.flush_ptr_i    = vecs[r].fp;
            bus.rd_idx_i       = vecs[r].ri;
            #1;
            if (vecs[r].cs) begin
                check("enq_ready", r, 32'(bus.enq_ready_o), 32'(vecs[r].e_ready));
                check("fetch_valid", r, 32'(bus.fetch_valid_o), 32'(vecs[r].e_fv));
                check("count", r, 32'(bus.count_o), 32'(vecs[r].e_cnt));
                check("empty", r, 32'(bus.empty_o), 32'(vecs[r].e_cnt == 4'd0));
                check("fetch_idx", r, 32'(bus.fetch_idx_o), 32'(vecs[r].e_fidx));
            end
            if (vecs[r].cp) begin
                check("fetch_pc", r, bus.fetch_pc_o, vecs[r].e_fpc);
                check("fetch_taken", r, 32'(bus.fetch_taken_o), 32'(f_taken(vecs[r].e_fpc)));
                check("fetch_slot", r, 32'(bus.fetch_slot_o), 32'(f_slot(vecs[r].e_fpc)));
                check("fetch_target", r, bus.fetch_target_o, f_tgt(vecs[r].e_fpc));
            end
            if (vecs[r].cr)
                check("rd_pc", r, bus.rd_pc_o, vecs[r].e_rpc);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
